// File: rtl/gf180mcu_fd_sc_mcu7t5v0__and3_bist_if.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__and3_bist_if
//
// Purpose: bundles the signals between the AND3 BIST engine and its
//          surroundings: the cell under test and the run controller.
//
// Signals:
//   START     run request (controller -> BIST)
//   ZI        Z output of the cell under test (cell -> BIST)
//   A1..A3    registered drives to the cell inputs (BIST -> cell)
//   BUSY      run in progress
//   DONE      one-cycle pulse when a run completes
//   PASS      last completed run had zero mismatches
//   ERR_CNT   saturating mismatch count of the current/last run
//   FAIL_SEEN at least one mismatch in the current/last run
//   FAIL_VEC  {A3,A2,A1} of the first mismatching vector
//
// Modports:
//   master  the BIST engine side
//   slave   the cell / controller side
// -----------------------------------------------------------------------------
interface gf180mcu_fd_sc_mcu7t5v0__and3_bist_if #(
    parameter int ERR_W = 4
);
    logic             START;
    logic             ZI;
    logic             A1;
    logic             A2;
    logic             A3;
    logic             BUSY;
    logic             DONE;
    logic             PASS;
    logic [ERR_W-1:0] ERR_CNT;
    logic             FAIL_SEEN;
    logic [2:0]       FAIL_VEC;

    modport master (
        input  START, ZI,
        output A1, A2, A3, BUSY, DONE, PASS, ERR_CNT, FAIL_SEEN, FAIL_VEC
    );

    modport slave (
        output START, ZI,
        input  A1, A2, A3, BUSY, DONE, PASS, ERR_CNT, FAIL_SEEN, FAIL_VEC
    );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__and3_bist.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__and3_bist
//
// Purpose: built-in self-test driver/checker for a 3-input AND cell. Sweeps
//          all eight {A3,A2,A1} vectors, holds each for SETTLE_CYCLES+1
//          cycles, samples the cell's Z on the last cycle of the hold and
//          compares it with A1&A2&A3. Mismatches are counted (saturating),
//          the first failing vector is captured and a pass/fail verdict is
//          published when the run completes.
//
// Parameters:
//   SETTLE_CYCLES  extra cycles each vector is held before sampling (0..255)
//   NUM_PASSES     full 8-vector sweeps per run (1..16)
//   ERR_W          width of the saturating mismatch counter
//
// Ports:
//   CLK   rising-edge clock
//   RST   asynchronous, active-high reset; aborts any run without DONE
//   bus   master side of the BIST interface (START/ZI in, drives and
//         status out)
// -----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__and3_bist #(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1,
    parameter int ERR_W         = 4
) (
    input  logic                                       CLK,
    input  logic                                       RST,
    gf180mcu_fd_sc_mcu7t5v0__and3_bist_if.master       bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);
    localparam logic [3:0] LAST_PASS   = 4'(NUM_PASSES - 1);

    state_t           state;
    state_t           state_nxt;

    logic [2:0]       vec;        // vector currently driven
    logic [3:0]       pass_idx;   // sweep number within the run
    logic [7:0]       cnt;        // remaining settle cycles for this vector
    logic [2:0]       a_q;        // registered cell drive {A3,A2,A1}
    logic [ERR_W-1:0] err_cnt;
    logic             fail_seen;
    logic [2:0]       fail_vec;
    logic             pass_q;

    logic             busy;
    logic             done;

    logic             sample;
    logic             mismatch;
    logic             last_vec;

    // A sample happens on the final cycle of each vector's hold window.
    assign sample   = (state == RUN) && (cnt == 8'd0);
    assign mismatch = sample && (bus.ZI != (&vec));
    assign last_vec = (vec == 3'd7) && (pass_idx == LAST_PASS);

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and process ordering cannot change behaviour.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps every path assigned, so
    // no latch is inferred for state_nxt.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.START)          state_nxt = RUN;
            RUN:  if (sample && last_vec) state_nxt = FIN;
            FIN:                          state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Output decode (state is registered, so these are glitch-free)
    // ---------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            RUN:     busy = 1'b1;
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // Sweep datapath and result registers
    // ---------------------------------------------------------------------
    // a_q always equals vec while in RUN and 000 otherwise; it is updated on
    // the same edge that moves vec/state so the drive is a clean flop output.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vec       <= 3'd0;
            pass_idx  <= 4'd0;
            cnt       <= 8'd0;
            a_q       <= 3'd0;
            err_cnt   <= '0;
            fail_seen <= 1'b0;
            fail_vec  <= 3'd0;
            pass_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.START) begin
                        vec       <= 3'd0;
                        pass_idx  <= 4'd0;
                        cnt       <= SETTLE_LOAD;
                        a_q       <= 3'd0;
                        err_cnt   <= '0;
                        fail_seen <= 1'b0;
                        fail_vec  <= 3'd0;
                        pass_q    <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        if (mismatch) begin
                            if (err_cnt != '1) begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                            if (!fail_seen) begin
                                fail_seen <= 1'b1;
                                fail_vec  <= vec;
                            end
                        end
                        if (last_vec) begin
                            // Verdict includes the mismatch sampled on this edge.
                            a_q    <= 3'd0;
                            pass_q <= !(fail_seen || mismatch);
                        end else begin
                            vec <= vec + 3'd1;
                            a_q <= vec + 3'd1;
                            cnt <= SETTLE_LOAD;
                            if (vec == 3'd7) begin
                                pass_idx <= pass_idx + 4'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.A1        = a_q[0];
    assign bus.A2        = a_q[1];
    assign bus.A3        = a_q[2];
    assign bus.BUSY      = busy;
    assign bus.DONE      = done;
    assign bus.PASS      = pass_q;
    assign bus.ERR_CNT   = err_cnt;
    assign bus.FAIL_SEEN = fail_seen;
    assign bus.FAIL_VEC  = fail_vec;

endmodule
